// File: rtl/isa_pkg.sv
// Shared ISA operation encodings used by the execute and memory stages.
package isa_pkg;

   localparam logic [7:0] OP_ADD = 8'h01;
   localparam logic [7:0] OP_SUB = 8'h02;
   localparam logic [7:0] OP_AND = 8'h03;
   localparam logic [7:0] OP_OR  = 8'h04;
   localparam logic [7:0] OP_LB  = 8'h10;
   localparam logic [7:0] OP_LH  = 8'h11;
   localparam logic [7:0] OP_LW  = 8'h12;
   localparam logic [7:0] OP_LBU = 8'h14;
   localparam logic [7:0] OP_LHU = 8'h15;
   localparam logic [7:0] OP_SB  = 8'h18;
   localparam logic [7:0] OP_SH  = 8'h19;
   localparam logic [7:0] OP_SW  = 8'h1A;

endpackage

// File: rtl/lsu_pkg.sv
// Load/store unit types and helpers: FSM state, access size and op classification.
package lsu_pkg;
   import isa_pkg::*;

   localparam int BE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } lsu_state_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } lsu_size_e;

   function automatic logic is_load(input logic [7:0] op);
      return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
             (op == OP_LBU) || (op == OP_LHU);
   endfunction

   function automatic logic is_store(input logic [7:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic lsu_size_e access_size(input logic [7:0] op);
      if ((op == OP_LB) || (op == OP_LBU) || (op == OP_SB)) return SZ_BYTE;
      if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) return SZ_HALF;
      return SZ_WORD;
   endfunction

   function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] a);
      case (access_size(op))
         SZ_HALF: return a[0];
         SZ_WORD: return a != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_formatter.sv
// Selects the addressed byte/half of a returned word and sign- or zero-extends it.
module load_formatter
   import isa_pkg::*;
(
   input  logic [7:0]  op_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] word_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[8*addr_lo_i +: 8];
      half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
      case (op_i)
         OP_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  data_o = {24'd0, byte_sel};
         OP_LH:   data_o = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  data_o = {16'd0, half_sel};
         default: data_o = word_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: req/gnt/rvalid data port, lane steering and load extension.
// Define LSU_MISALIGNED_TRAP_EN to answer misaligned accesses with a flagged response instead of a memory access.
module load_store_unit
   import isa_pkg::*;
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [7:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              busy,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_misaligned,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [BE_W-1:0]   mem_be,
   output logic [31:0]       mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata
);

   // state   | meaning
   // IDLE    | ready to accept a load/store
   // REQ     | mem_req asserted, waiting for mem_gnt
   // WAIT    | load granted, waiting for mem_rvalid
   // RESP    | one-cycle response to writeback

   lsu_state_e        state_q, state_d;
   logic [7:0]        op_q;
   logic [1:0]        addr_lo_q;
   logic [ADDR_W-1:0] addr_q;
   logic [BE_W-1:0]   be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              we_q;
   logic [31:0]       rdata_q;
   logic [31:0]       fmt_data;
   logic              accept;
   logic [1:0]        a;

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && (is_load(req_op) || is_store(req_op))) begin
               accept = 1'b1;
`ifdef LSU_MISALIGNED_TRAP_EN
               state_d = is_misaligned(req_op, req_addr[1:0]) ? ST_RESP : ST_REQ;
`else
               state_d = ST_REQ;
`endif
            end
         end
         ST_REQ:  if (mem_gnt) state_d = is_store(op_q) ? ST_RESP : ST_WAIT;
         ST_WAIT: if (mem_rvalid) state_d = ST_RESP;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Loads drive a full-word read; the formatter picks the lane on return.
   always_comb begin
      a       = req_addr[1:0];
      be_d    = 4'b1111;
      wdata_d = '0;
      if (is_store(req_op)) begin
         wdata_d = req_wdata;
         case (access_size(req_op))
            SZ_BYTE: begin
               be_d    = 4'b0001 << a;
               wdata_d = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
               be_d    = 4'b0011 << {a[1], 1'b0};
               wdata_d = {2{req_wdata[15:0]}};
            end
            default: be_d = 4'b1111;
         endcase
      end
   end

   load_formatter u_fmt (
      .op_i      (op_q),
      .addr_lo_i (addr_lo_q),
      .word_i    (mem_rdata),
      .data_o    (fmt_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         op_q      <= '0;
         addr_lo_q <= '0;
         addr_q    <= '0;
         be_q      <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q      <= req_op;
            addr_lo_q <= req_addr[1:0];
            addr_q    <= {req_addr[ADDR_W-1:2], 2'b00};
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            we_q      <= is_store(req_op);
            rdata_q   <= '0;
         end
         if ((state_q == ST_WAIT) && mem_rvalid) rdata_q <= fmt_data;
      end
   end

`ifdef LSU_MISALIGNED_TRAP_EN
   logic misal_q;

   always_ff @(posedge clk) begin
      if (!rst_n)      misal_q <= 1'b0;
      else if (accept) misal_q <= is_misaligned(req_op, req_addr[1:0]);
   end

   assign resp_misaligned = misal_q;
`else
   assign resp_misaligned = 1'b0;
`endif

   assign req_ready  = (state_q == ST_IDLE);
   assign busy       = !req_ready;
   assign resp_valid = (state_q == ST_RESP);
   assign resp_rdata = rdata_q;
   assign mem_req    = (state_q == ST_REQ);
   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_be     = be_q;
   assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized accesses against a behavioural model.
module tb_load_store_unit;
   import isa_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [7:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        busy;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_misaligned;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int tests = 0;
   int fails = 0;

`ifdef LSU_MISALIGNED_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   load_store_unit #(.ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Results captured by run_access
   logic        r_ready_start, r_timeout, r_saw_req, r_unstable, r_busy_drop;
   int          r_lat;
   logic [31:0] r_rdata, r_addr, r_wdata;
   logic        r_mis, r_we;
   logic [3:0]  r_be;

   // ---------------- reference model ----------------
   function automatic bit m_is_store(input logic [7:0] op);
      return op == OP_SB || op == OP_SH || op == OP_SW;
   endfunction

   function automatic int m_bytes(input logic [7:0] op);
      if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
      if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
      return 4;
   endfunction

   function automatic bit m_misaligned(input logic [7:0] op, input logic [31:0] addr);
      return (addr % m_bytes(op)) != 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [7:0] op, input logic [31:0] addr);
      int a;
      a = addr % 4;
      if (op == OP_SB) return 4'(1 << a);
      if (op == OP_SH) return (a >= 2) ? 4'b1100 : 4'b0011;
      return 4'b1111;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] wd);
      if (op == OP_SB) return (wd % 256) * 32'h0101_0101;
      if (op == OP_SH) return (wd % 65536) * 32'h0001_0001;
      return wd;
   endfunction

   function automatic logic [31:0] m_rdata(input logic [7:0] op, input logic [31:0] addr,
                                           input logic [31:0] raw);
      int a;
      longint v;
      a = addr % 4;
      if (op == OP_LB || op == OP_LBU) begin
         v = (raw >> (8 * a)) % 256;
         if (op == OP_LB && v > 127) v = v - 256;
         return 32'(v);
      end
      if (op == OP_LH || op == OP_LHU) begin
         v = (raw >> (16 * (a / 2))) % 65536;
         if (op == OP_LH && v > 32767) v = v - 65536;
         return 32'(v);
      end
      return raw;
   endfunction

   // ---------------- driver ----------------
   task automatic run_access(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd,
                             input int gd, input int rd, input logic [31:0] raw, input bit noise);
      int  gcnt, wcnt;
      bit  granted, rv_sent;
      r_timeout = 1'b1; r_saw_req = 1'b0; r_unstable = 1'b0; r_busy_drop = 1'b0;
      r_lat = 0; r_rdata = '0; r_mis = 1'b0;
      gcnt = 0; wcnt = 0; granted = 1'b0; rv_sent = 1'b0;
      @(negedge clk);
      r_ready_start = req_ready;
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         @(negedge clk);
         req_valid = 1'b0; req_op = OP_ADD; req_addr = $urandom; req_wdata = $urandom;
         mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
         if (resp_valid) begin
            r_lat = cyc; r_rdata = resp_rdata; r_mis = resp_misaligned; r_timeout = 1'b0;
            break;
         end
         if (!busy) r_busy_drop = 1'b1;
         if (mem_req) begin
            if (!r_saw_req) begin
               r_addr = mem_addr; r_be = mem_be; r_wdata = mem_wdata; r_we = mem_we;
            end else if (mem_addr !== r_addr || mem_be !== r_be || mem_wdata !== r_wdata ||
                         mem_we !== r_we) begin
               r_unstable = 1'b1;
            end
            r_saw_req = 1'b1;
            if (gcnt == gd) begin
               mem_gnt = 1'b1; granted = 1'b1;
            end else if (noise) begin
               mem_rvalid = 1'($urandom_range(0, 1));
            end
            gcnt++;
         end else if (granted && !rv_sent) begin
            if (wcnt == rd) begin
               mem_rvalid = 1'b1; mem_rdata = raw; rv_sent = 1'b1;
            end
            wcnt++;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
      tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
      tests++; if (resp_rdata !== 32'd0) begin fails++; $display("FAIL reset_resp_rdata got %h want 0", resp_rdata); end
      tests++; if (resp_misaligned !== 1'b0) begin fails++; $display("FAIL reset_resp_mis got %b want 0", resp_misaligned); end
      tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
      tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
      tests++; if (mem_addr !== 32'd0) begin fails++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
      tests++; if (mem_be !== 4'd0) begin fails++; $display("FAIL reset_mem_be got %b want 0", mem_be); end
      tests++; if (mem_wdata !== 32'd0) begin fails++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
      rst_n = 1'b1;
   endtask

   task automatic test_store_sb();
      run_access(OP_SB, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'h0, 1'b0);
      tests++; if (r_timeout) begin fails++; $display("FAIL sb_timeout no resp_valid"); end
      tests++; if (r_ready_start !== 1'b1) begin fails++; $display("FAIL sb_ready got %b want 1", r_ready_start); end
      tests++; if (r_addr !== 32'h0000_1000) begin fails++; $display("FAIL sb_addr got %h want 00001000", r_addr); end
      tests++; if (r_be !== 4'b1000) begin fails++; $display("FAIL sb_be got %b want 1000", r_be); end
      tests++; if (r_wdata !== 32'hA5A5_A5A5) begin fails++; $display("FAIL sb_wdata got %h want a5a5a5a5", r_wdata); end
      tests++; if (r_we !== 1'b1) begin fails++; $display("FAIL sb_we got %b want 1", r_we); end
      tests++; if (r_lat != 2) begin fails++; $display("FAIL sb_latency got %0d want 2", r_lat); end
      tests++; if (r_rdata !== 32'd0) begin fails++; $display("FAIL sb_rdata got %h want 0", r_rdata); end
   endtask

   task automatic test_load_sign();
      run_access(OP_LB, 32'h0000_2002, 32'h0, 0, 0, 32'h0080_0000, 1'b0);
      tests++; if (r_timeout || r_rdata !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb_rdata got %h want ffffff80", r_rdata); end
      tests++; if (r_lat != 3) begin fails++; $display("FAIL lb_latency got %0d want 3", r_lat); end
      tests++; if (r_we !== 1'b0 || r_be !== 4'b1111) begin fails++; $display("FAIL lb_we_be got we=%b be=%b want we=0 be=1111", r_we, r_be); end
      run_access(OP_LBU, 32'h0000_2002, 32'h0, 0, 0, 32'h0080_0000, 1'b0);
      tests++; if (r_timeout || r_rdata !== 32'h0000_0080) begin fails++; $display("FAIL lbu_rdata got %h want 00000080", r_rdata); end
   endtask

   task automatic test_stall();
      run_access(OP_LHU, 32'h0000_2002, 32'h0, 3, 2, 32'hBEEF_1234, 1'b1);
      tests++; if (r_timeout || r_rdata !== 32'h0000_BEEF) begin fails++; $display("FAIL lhu_rdata got %h want 0000beef", r_rdata); end
      tests++; if (r_lat != 8) begin fails++; $display("FAIL lhu_latency got %0d want 8", r_lat); end
      tests++; if (r_busy_drop) begin fails++; $display("FAIL lhu_busy got busy low want high"); end
      tests++; if (r_unstable) begin fails++; $display("FAIL lhu_stable got change want stable"); end
      tests++; if (r_addr !== 32'h0000_2000) begin fails++; $display("FAIL lhu_addr got %h want 00002000", r_addr); end
   endtask

   task automatic test_misaligned_lw();
      run_access(OP_LW, 32'h0000_3001, 32'h0, 0, 0, 32'h1234_5678, 1'b0);
      if (TRAP) begin
         tests++; if (r_timeout || r_saw_req) begin fails++; $display("FAIL lw_mis_noreq got saw_req=%b timeout=%b want 0 0", r_saw_req, r_timeout); end
         tests++; if (r_mis !== 1'b1 || r_rdata !== 32'd0) begin fails++; $display("FAIL lw_mis_flag got mis=%b rdata=%h want 1 0", r_mis, r_rdata); end
      end else begin
         tests++; if (r_addr !== 32'h0000_3000 || r_be !== 4'b1111) begin fails++; $display("FAIL lw_unal_addr got %h be=%b want 00003000 1111", r_addr, r_be); end
         tests++; if (r_timeout || r_rdata !== 32'h1234_5678 || r_mis !== 1'b0) begin fails++; $display("FAIL lw_unal_rdata got %h mis=%b want 12345678 0", r_rdata, r_mis); end
      end
   endtask

   task automatic test_reset_in_wait();
      bit seen_resp;
      seen_resp = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h0000_4000; req_wdata = '0;
      @(negedge clk);
      req_valid = 1'b0; req_op = OP_ADD;
      tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rstwait_req got %b want 1", mem_req); end
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      tests++; if (req_ready !== 1'b1 || mem_req !== 1'b0) begin fails++; $display("FAIL rstwait_idle got ready=%b req=%b want 1 0", req_ready, mem_req); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         mem_rvalid = 1'b0;
         if (resp_valid) seen_resp = 1'b1;
      end
      tests++; if (seen_resp || req_ready !== 1'b1) begin fails++; $display("FAIL rstwait_noresp got resp=%b ready=%b want 0 1", seen_resp, req_ready); end
   endtask

   task automatic test_non_mem_op();
      bit bad;
      bad = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_op = OP_ADD; req_addr = 32'h0000_5000; req_wdata = 32'h1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (!req_ready || mem_req || resp_valid) bad = 1'b1;
      end
      req_valid = 1'b0;
      tests++; if (bad) begin fails++; $display("FAIL add_ignored got acceptance want none"); end
   endtask

   task automatic test_random();
      logic [7:0]  ops [8];
      logic [7:0]  op;
      logic [31:0] addr, wd, raw;
      int          gd, rd, exp_lat;
      bit          mis;
      ops[0] = OP_LB; ops[1] = OP_LH; ops[2] = OP_LW; ops[3] = OP_LBU;
      ops[4] = OP_LHU; ops[5] = OP_SB; ops[6] = OP_SH; ops[7] = OP_SW;
      for (int n = 0; n < 40; n++) begin
         op   = ops[$urandom_range(0, 7)];
         addr = $urandom; wd = $urandom; raw = $urandom;
         gd   = $urandom_range(0, 3); rd = $urandom_range(0, 3);
         mis  = TRAP && m_misaligned(op, addr);
         run_access(op, addr, wd, gd, rd, raw, 1'b1);
         exp_lat = mis ? 1 : (m_is_store(op) ? 2 + gd : 3 + gd + rd);
         tests++;
         if (r_timeout || r_lat != exp_lat || r_mis !== mis || r_ready_start !== 1'b1 || r_busy_drop || r_unstable) begin
            fails++;
            $display("FAIL rnd_ctrl op=%h addr=%h got lat=%0d mis=%b ready=%b want lat=%0d mis=%b ready=1",
                     op, addr, r_lat, r_mis, r_ready_start, exp_lat, mis);
         end
         tests++;
         if (r_rdata !== ((mis || m_is_store(op)) ? 32'd0 : m_rdata(op, addr, raw))) begin
            fails++;
            $display("FAIL rnd_rdata op=%h addr=%h raw=%h got %h want %h", op, addr, raw, r_rdata,
                     (mis || m_is_store(op)) ? 32'd0 : m_rdata(op, addr, raw));
         end
         if (!mis) begin
            tests++;
            if (r_addr !== (addr & 32'hFFFF_FFFC) || r_be !== m_be(op, addr) || r_we !== m_is_store(op) ||
                (m_is_store(op) && r_wdata !== m_wdata(op, wd))) begin
               fails++;
               $display("FAIL rnd_mem op=%h addr=%h got a=%h be=%b we=%b wd=%h want a=%h be=%b we=%b wd=%h",
                        op, addr, r_addr, r_be, r_we, r_wdata, addr & 32'hFFFF_FFFC, m_be(op, addr),
                        m_is_store(op), m_wdata(op, wd));
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_op = OP_ADD; req_addr = '0; req_wdata = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      test_reset();
      test_store_sb();
      test_load_sign();
      test_stall();
      test_misaligned_lw();
      test_reset_in_wait();
      test_non_mem_op();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
